pfa_addr_gen: RTL and testbench

Streaming prime-factor-algorithm (Good–Thomas) index generator for up to three coprime factors Nf1·Nf2·Nf3 = N. On `start` it latches the factors and emits all N index tuples in order, one per handshake, in either input (Ruritanian) or output (CRT) mapping mode. It supersedes the fixed three-counter PFA address translator by adding a run-time mode, a valid/ready output handshake, frame markers and parametrised widths. It sits between the PFA controller and the data-buffer read/write address ports.

---
 rtl/pfa_pkg.sv | 20 ++
 rtl/pfa_mod_cnt.sv | 44 ++++
 rtl/pfa_addr_gen.sv | 274 +++++++++++++++++++++++++++
 tb/tb_pfa_addr_gen.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pfa_pkg.sv
// pfa_pkg: shared definitions for the PFA (Good-Thomas) index generator.
//   - default widths for factor / index outputs and the linear address
//   - mapping-mode encoding (input / Ruritanian vs output / CRT)
//   - FSM state type and state constants
package pfa_pkg;

   localparam int unsigned PFA_W_DATA = 16;
   localparam int unsigned PFA_W_ADDR = 12;

   typedef enum logic {
      PFA_MODE_IN  = 1'b0,
      PFA_MODE_OUT = 1'b1
   } pfa_mode_e;

   typedef logic [0:0] pfa_state_t;

   localparam pfa_state_t ST_IDLE = 1'b0;
   localparam pfa_state_t ST_RUN  = 1'b1;

endpackage

// File: rtl/pfa_mod_cnt.sv
// pfa_mod_cnt: modulo counter, counts 0..modulus-1 on en and wraps to 0.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear to 0 (dominates en)
//   en         : advance by one
//   modulus    : wrap modulus (must be non-zero while counting)
//   cnt        : current count (registered)
//   wrap_c     : en while cnt is at modulus-1 (combinational)
module pfa_mod_cnt #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] modulus,
   output logic [W-1:0] cnt,
   output logic         wrap_c
);

   logic [W-1:0] cnt_nxt;

   assign wrap_c = en && (cnt == (modulus - W'(1)));

   // next count: clear wins, then wrap, then increment
   always_comb begin
      cnt_nxt = cnt;
      if (clr) begin
         cnt_nxt = '0;
      end else if (wrap_c) begin
         cnt_nxt = '0;
      end else if (en) begin
         cnt_nxt = cnt + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_nxt;
      end
   end

endmodule

// File: rtl/pfa_addr_gen.sv
// pfa_addr_gen: streaming prime-factor (Good-Thomas) index generator.
// On start, latches Nf1..Nf3 and mode, then emits all N = Nf1*Nf2*Nf3 index
// tuples (k3 fastest) over a valid/ready handshake.
//   mode 0 (input map) : n = (k1,k2,k3), addr = sum of k_i*(N/Nf_i) mod N
//   mode 1 (output map): addr = linear index, n_i = addr mod Nf_i
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   clr                 : synchronous abort back to idle
//   start, mode         : frame request (idle only) and mapping mode
//   Nf1, Nf2, Nf3       : factors, latched at start
//   out_ready/out_valid : output handshake
//   n1, n2, n3, addr    : index tuple and linear address
//   sop, eop            : first / last tuple of frame
//   busy                : frame in progress
//   cfg_err             : one-cycle pulse, start rejected
//   addr_err            : sticky address-sum check failure
// Optional feature macro: PFA_ADDR_SUM_EN enables the address-sum check;
// without it addr_err is constant 0.
module pfa_addr_gen
   import pfa_pkg::*;
#(
   parameter int unsigned wDataInOut = PFA_W_DATA,
   parameter int unsigned wAddr      = PFA_W_ADDR
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  start,
   input  logic                  mode,
   input  logic [wDataInOut-1:0] Nf1,
   input  logic [wDataInOut-1:0] Nf2,
   input  logic [wDataInOut-1:0] Nf3,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [wDataInOut-1:0] n1,
   output logic [wDataInOut-1:0] n2,
   output logic [wDataInOut-1:0] n3,
   output logic [wAddr-1:0]      addr,
   output logic                  sop,
   output logic                  eop,
   output logic                  busy,
   output logic                  cfg_err,
   output logic                  addr_err
);

   localparam int unsigned PW = 3 * wDataInOut;
   localparam int unsigned TW = wAddr + 2;
   localparam int unsigned SW = 2 * wAddr;

   pfa_state_t            state, state_d;
   logic                  prep, prep_d;
   pfa_mode_e             mode_q;
   logic [wDataInOut-1:0] f1, f2, f3;
   logic [wAddr-1:0]      n_q;
   logic [wAddr-1:0]      s1, s2, s3;
   logic [wAddr-1:0]      t1, t2, t3, t1_d, t2_d, t3_d;
   logic [wAddr-1:0]      lin, lin_d;
   logic [wAddr-1:0]      addr_in_c, addr_d;
   logic [TW-1:0]         sum3;
   logic [PW-1:0]         prod_c;
   logic                  cfg_bad_c, accept_c, fire_c, cnt_clr_c, t_adv;
   logic                  en1_c, en2_c, en3_c, w1_c, w2_c, w3_c;
   logic                  out_valid_d, sop_d, eop_d, busy_d, cfg_err_d;

   // (a + b) mod m for a, b < m
   function automatic logic [wAddr-1:0] add_mod(input logic [wAddr-1:0] a,
                                                input logic [wAddr-1:0] b,
                                                input logic [wAddr-1:0] m);
      logic [wAddr:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, m}) s = s - {1'b0, m};
      return s[wAddr-1:0];
   endfunction

   // start validation: any zero factor or N not representable in addr
   assign prod_c    = PW'(Nf1) * PW'(Nf2) * PW'(Nf3);
   assign cfg_bad_c = (Nf1 == '0) || (Nf2 == '0) || (Nf3 == '0) ||
                      (prod_c >= (PW'(1) << wAddr));
   assign accept_c  = (state == ST_IDLE) && start && !cfg_bad_c && !clr;
   assign fire_c    = out_valid && out_ready;
   // counters/terms return to zero on abort, new frame, or after the last tuple
   assign cnt_clr_c = clr || accept_c || (fire_c && eop);

   // mode 0 nests the loops (k3 fastest); mode 1 steps all residues together
   assign en3_c = fire_c;
   assign en2_c = (mode_q == PFA_MODE_OUT) ? fire_c : (fire_c && w3_c);
   assign en1_c = (mode_q == PFA_MODE_OUT) ? fire_c : (en2_c && w2_c);

   // counters drive the index outputs directly
   pfa_mod_cnt #(.W(wDataInOut)) u_cnt1 (
      .clk(clk), .rst_n(rst_n), .clr(cnt_clr_c), .en(en1_c),
      .modulus(f1), .cnt(n1), .wrap_c(w1_c)
   );
   pfa_mod_cnt #(.W(wDataInOut)) u_cnt2 (
      .clk(clk), .rst_n(rst_n), .clr(cnt_clr_c), .en(en2_c),
      .modulus(f2), .cnt(n2), .wrap_c(w2_c)
   );
   pfa_mod_cnt #(.W(wDataInOut)) u_cnt3 (
      .clk(clk), .rst_n(rst_n), .clr(cnt_clr_c), .en(en3_c),
      .modulus(f3), .cnt(n3), .wrap_c(w3_c)
   );

   // partial terms t_i = k_i*stride_i mod N, linear index, next addresses
   always_comb begin
      t_adv = fire_c && (mode_q == PFA_MODE_IN);
      lin_d = lin;
      t1_d  = t1;
      t2_d  = t2;
      t3_d  = t3;
      if (fire_c) lin_d = lin + wAddr'(1);
      if (t_adv) t3_d = w3_c ? '0 : add_mod(t3, s3, n_q);
      if (t_adv && en2_c) t2_d = w2_c ? '0 : add_mod(t2, s2, n_q);
      if (t_adv && en1_c) t1_d = w1_c ? '0 : add_mod(t1, s1, n_q);
      if (cnt_clr_c) begin
         lin_d = '0;
         t1_d  = '0;
         t2_d  = '0;
         t3_d  = '0;
      end
      // three terms each < N: two conditional subtractions suffice
      sum3 = TW'(t1_d) + TW'(t2_d) + TW'(t3_d);
      if (sum3 >= TW'(n_q)) sum3 = sum3 - TW'(n_q);
      if (sum3 >= TW'(n_q)) sum3 = sum3 - TW'(n_q);
      addr_in_c = sum3[wAddr-1:0];
      addr_d    = (mode_q == PFA_MODE_OUT) ? lin_d : addr_in_c;
   end

   // next state and registered outputs
   always_comb begin
      state_d     = state;
      prep_d      = 1'b0;
      out_valid_d = out_valid;
      sop_d       = sop;
      eop_d       = eop;
      busy_d      = busy;
      cfg_err_d   = 1'b0;
      case (state)
         ST_IDLE: begin
            out_valid_d = 1'b0;
            sop_d       = 1'b0;
            eop_d       = 1'b0;
            busy_d      = 1'b0;
            if (start) begin
               if (cfg_bad_c) begin
                  cfg_err_d = 1'b1;
               end else begin
                  state_d = ST_RUN;
                  prep_d  = 1'b1;
                  busy_d  = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (prep) begin
               // strides settle this cycle; tuple 0 is all zeros
               out_valid_d = 1'b1;
               sop_d       = 1'b1;
               eop_d       = (n_q == wAddr'(1));
            end else if (fire_c) begin
               if (eop) begin
                  state_d     = ST_IDLE;
                  out_valid_d = 1'b0;
                  sop_d       = 1'b0;
                  eop_d       = 1'b0;
                  busy_d      = 1'b0;
               end else begin
                  sop_d = 1'b0;
                  eop_d = (lin_d == (n_q - wAddr'(1)));
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (clr) begin
         state_d     = ST_IDLE;
         prep_d      = 1'b0;
         out_valid_d = 1'b0;
         sop_d       = 1'b0;
         eop_d       = 1'b0;
         busy_d      = 1'b0;
         cfg_err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         prep      <= 1'b0;
         out_valid <= 1'b0;
         sop       <= 1'b0;
         eop       <= 1'b0;
         busy      <= 1'b0;
         cfg_err   <= 1'b0;
         addr      <= '0;
         lin       <= '0;
         t1        <= '0;
         t2        <= '0;
         t3        <= '0;
      end else begin
         state     <= state_d;
         prep      <= prep_d;
         out_valid <= out_valid_d;
         sop       <= sop_d;
         eop       <= eop_d;
         busy      <= busy_d;
         cfg_err   <= cfg_err_d;
         lin       <= lin_d;
         t1        <= t1_d;
         t2        <= t2_d;
         t3        <= t3_d;
         if (clr || (fire_c && eop)) begin
            addr <= '0;
         end else if (prep) begin
            addr <= '0;
         end else if (fire_c) begin
            addr <= addr_d;
         end
      end
   end

   // frame configuration: factors at start, strides N/Nf_i mod N one cycle later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f1     <= '0;
         f2     <= '0;
         f3     <= '0;
         n_q    <= '0;
         mode_q <= PFA_MODE_IN;
         s1     <= '0;
         s2     <= '0;
         s3     <= '0;
      end else begin
         if (accept_c) begin
            f1     <= Nf1;
            f2     <= Nf2;
            f3     <= Nf3;
            n_q    <= wAddr'(prod_c);
            mode_q <= pfa_mode_e'(mode);
         end
         if (prep) begin
            // N/Nf_i equals N (== 0 mod N) only when Nf_i is 1
            s1 <= (f1 == wDataInOut'(1)) ? '0 : wAddr'(wAddr'(f2) * wAddr'(f3));
            s2 <= (f2 == wDataInOut'(1)) ? '0 : wAddr'(wAddr'(f1) * wAddr'(f3));
            s3 <= (f3 == wDataInOut'(1)) ? '0 : wAddr'(wAddr'(f1) * wAddr'(f2));
         end
      end
   end

`ifdef PFA_ADDR_SUM_EN
   logic [SW-1:0] sum_q, exp_sum;

   // every frame is a permutation of 0..N-1, so addresses must sum to N(N-1)/2
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q    <= '0;
         exp_sum  <= '0;
         addr_err <= 1'b0;
      end else if (clr) begin
         sum_q    <= '0;
         addr_err <= 1'b0;
      end else begin
         if (accept_c) sum_q <= '0;
         if (prep) exp_sum <= (SW'(n_q) * SW'(n_q - wAddr'(1))) >> 1;
         if (fire_c) begin
            sum_q <= sum_q + SW'(addr);
            if (eop && ((sum_q + SW'(addr)) != exp_sum)) addr_err <= 1'b1;
         end
      end
   end
`else
   assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_pfa_addr_gen.sv
`timescale 1ns/1ps
module tb_pfa_addr_gen;

   localparam int unsigned WD = 16;
   localparam int unsigned WA = 12;

   logic          clk = 1'b0;
   logic          rst_n, clr, start, mode, out_ready;
   logic [WD-1:0] Nf1, Nf2, Nf3;
   logic          out_valid, sop, eop, busy, cfg_err, addr_err;
   logic [WD-1:0] n1, n2, n3;
   logic [WA-1:0] addr;

   pfa_addr_gen #(.wDataInOut(WD), .wAddr(WA)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .mode(mode),
      .Nf1(Nf1), .Nf2(Nf2), .Nf3(Nf3), .out_ready(out_ready),
      .out_valid(out_valid), .n1(n1), .n2(n2), .n3(n3), .addr(addr),
      .sop(sop), .eop(eop), .busy(busy), .cfg_err(cfg_err), .addr_err(addr_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int n1, n2, n3, addr;
      bit sop, eop;
   } tup_t;

   tup_t exp_q[$];
   int   seen[int];
   int   total = 0;
   int   bad   = 0;
   int   fires = 0;
   bit   rand_ready = 1'b0;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // reference: enumerate the frame directly from the index-mapping rules
   task automatic push_frame(input int f1, input int f2, input int f3, input bit m);
      int   n;
      tup_t t;
      n = f1 * f2 * f3;
      for (int i = 0; i < n; i++) begin
         if (m) begin
            t.addr = i;
            t.n1   = i % f1;
            t.n2   = i % f2;
            t.n3   = i % f3;
         end else begin
            t.n1   = i / (f2 * f3);
            t.n2   = (i / f3) % f2;
            t.n3   = i % f3;
            t.addr = (t.n1 * f2 * f3 + t.n2 * f1 * f3 + t.n3 * f1 * f2) % n;
         end
         t.sop = (i == 0);
         t.eop = (i == n - 1);
         exp_q.push_back(t);
      end
   endtask

   // downstream ready: always high, or random when rand_ready is set
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = rand_ready ? ($urandom_range(0, 99) < 55) : 1'b1;
      end
   end

   // monitor: hold check while stalled, scoreboard pop on each handshake
   initial begin
      logic [3*WD+WA+1:0] held;
      bit   stalled;
      tup_t e;
      stalled = 1'b0;
      held    = '0;
      forever begin
         @(negedge clk);
         if (stalled && out_valid) begin
            total++;
            if ({n1, n2, n3, addr, sop, eop} != held) begin
               bad++;
               $display("FAIL stall_hold: got %h, want %h (t=%0t)",
                        {n1, n2, n3, addr, sop, eop}, held, $time);
            end
         end
         stalled = out_valid && !out_ready;
         held    = {n1, n2, n3, addr, sop, eop};
         if (out_valid && out_ready) begin
            fires++;
            total++;
            seen[int'(addr)] = 1;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL tuple_extra: got addr=%0d, want no tuple (t=%0t)", addr, $time);
            end else begin
               e = exp_q.pop_front();
               if (int'(n1) != e.n1 || int'(n2) != e.n2 || int'(n3) != e.n3 ||
                   int'(addr) != e.addr || sop != e.sop || eop != e.eop) begin
                  bad++;
                  $display("FAIL tuple: got n=(%0d,%0d,%0d) addr=%0d sop=%0d eop=%0d, want n=(%0d,%0d,%0d) addr=%0d sop=%0d eop=%0d",
                           n1, n2, n3, addr, sop, eop, e.n1, e.n2, e.n3, e.addr, e.sop, e.eop);
               end
            end
         end
      end
   end

   // one frame request; now=1 asserts start in the current (idle) cycle
   task automatic run_frame(input int f1, input int f2, input int f3, input bit m,
                            input bit ok, input bit now, input bit poke);
      int n, c;
      n = f1 * f2 * f3;
      if (!now) begin
         @(posedge clk);
         #1;
      end
      if (ok) begin
         push_frame(f1, f2, f3, m);
         seen.delete();
      end
      Nf1   = WD'(f1);
      Nf2   = WD'(f2);
      Nf3   = WD'(f3);
      mode  = m;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      Nf1   = WD'($urandom_range(1, 9));
      Nf2   = WD'($urandom_range(1, 9));
      Nf3   = WD'($urandom_range(1, 9));
      mode  = ~m;
      @(negedge clk);
      chk("busy_cycle1", busy, ok);
      chk("cfg_err_cycle1", cfg_err, !ok);
      chk("valid_cycle1", out_valid, 0);
      @(negedge clk);
      chk("cfg_err_cycle2", cfg_err, 0);
      if (!ok) begin
         chk("busy_after_reject", busy, 0);
         return;
      end
      chk("valid_cycle2", out_valid, 1);
      chk("sop_cycle2", sop, 1);
      if (poke) begin
         repeat (5) @(posedge clk);
         #1;
         Nf1   = WD'(2);
         Nf2   = WD'(3);
         Nf3   = WD'(5);
         start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      c = 2;
      while (busy && c < 4 * n + 40) begin
         @(negedge clk);
         c++;
      end
      chk("frame_done", busy, 0);
      if (!rand_ready && !poke) chk("frame_cycles", c, n + 2);
      chk("queue_drain", exp_q.size(), 0);
      if (!m) chk("addr_distinct", seen.num(), n);
      chk("addr_err", addr_err, 0);
      chk("valid_idle", out_valid, 0);
   endtask

   int tri_tab[8][3] = '{'{2, 3, 5}, '{3, 4, 5}, '{7, 2, 3}, '{5, 7, 1},
                         '{1, 9, 4}, '{8, 9, 5}, '{3, 1, 1}, '{11, 3, 2}};

   initial begin
      int c, f0, k;
      rst_n = 1'b0;
      clr   = 1'b0;
      start = 1'b0;
      mode  = 1'b0;
      Nf1   = '0;
      Nf2   = '0;
      Nf3   = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_addr_err", addr_err, 0);
      chk("rst_addr", addr, 0);
      chk("rst_sop_eop", {sop, eop}, 0);

      // output map, then input map started in the cycle busy falls
      run_frame(4, 5, 3, 1'b1, 1'b1, 1'b0, 1'b0);
      run_frame(4, 5, 3, 1'b0, 1'b1, 1'b1, 1'b0);

      // random stalls plus an ignored start mid-frame
      rand_ready = 1'b1;
      run_frame(4, 5, 3, 1'b0, 1'b1, 1'b0, 1'b1);
      rand_ready = 1'b0;

      // single-tuple frame and zero factor
      run_frame(1, 1, 1, 1'b0, 1'b1, 1'b0, 1'b0);
      run_frame(4, 0, 3, 1'b0, 1'b0, 1'b0, 1'b0);

      // abort after 20 tuples, then a fresh frame
      @(posedge clk);
      #1;
      push_frame(4, 5, 3, 1'b0);
      f0    = fires;
      Nf1   = WD'(4);
      Nf2   = WD'(5);
      Nf3   = WD'(3);
      mode  = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      c = 0;
      while (fires - f0 < 20 && c < 200) begin
         @(posedge clk);
         #1;
         c++;
      end
      chk("clr_reached_tuple20", fires - f0, 20);
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("clr_valid_low", out_valid, 0);
      chk("clr_busy_low", busy, 0);
      chk("clr_no_eop", eop, 0);
      run_frame(4, 5, 3, 1'b0, 1'b1, 1'b0, 1'b0);

      // largest legal N, then one just over the address range
      rand_ready = 1'b1;
      run_frame(16, 17, 15, 1'b0, 1'b1, 1'b0, 1'b0);
      run_frame(16, 17, 16, 1'b0, 1'b0, 1'b0, 1'b0);

      // random coprime frames, random mode and stalls
      for (int i = 0; i < 6; i++) begin
         k = $urandom_range(0, 7);
         rand_ready = ($urandom_range(0, 1) == 1);
         run_frame(tri_tab[k][0], tri_tab[k][1], tri_tab[k][2],
                   ($urandom_range(0, 1) == 1), 1'b1, 1'b0, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
